// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: states, opcodes,
// funct codes, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADDR  = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_RWB      = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // States that hold the memory port and can stretch on memReady.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mips_mc_control_alu_ctl_decode.sv
// R-type funct decode: ALU operation code plus a legality flag used both by
// EXEC and by the DECODE illegal-instruction check.
module alu_ctl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_ctl,
    output logic       valid
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        alu_ctl = ALU_ADD;
        valid   = 1'b1;
        case (funct)
            FN_ADD:  alu_ctl = ALU_ADD;
            FN_SUB:  alu_ctl = ALU_SUB;
            FN_AND:  alu_ctl = ALU_AND;
            FN_OR:   alu_ctl = ALU_OR;
            FN_SLT:  alu_ctl = ALU_SLT;
            default: valid   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS main controller: Moore FSM with memReady-stretched memory
// states and a watchdog that abandons accesses stuck for WAIT_MAX cycles.
module mips_mc_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       pcEn,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluCtl,
    output logic [1:0] pcSource,
    output logic       illegalOp,
    output logic       memTimeout,
    output logic [3:0] state
);

    localparam int unsigned          CNT_W     = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam bit                   WD_EN     = (WAIT_MAX != 0);
    localparam logic [CNT_W-1:0]     CNT_LIMIT = WD_EN ? CNT_W'(WAIT_MAX - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_store;
    logic [2:0]       fn_alu;
    logic             fn_valid;
    logic             in_wait;
    logic             timeout;
    logic             stall;

    alu_ctl_decode u_alu_ctl_decode (
        .funct   (funct),
        .alu_ctl (fn_alu),
        .valid   (fn_valid)
    );

    assign in_wait = is_wait_state(state_q);
    // A memReady arriving on the limit cycle completes the access instead.
    assign timeout = WD_EN && in_wait && !memReady && (wait_cnt == CNT_LIMIT);
    assign stall   = in_wait && !memReady && !timeout;
    assign state   = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (memReady) state_d = S_DECODE;
                        else if (timeout) state_d = S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = fn_valid ? S_EXEC : S_FETCH;
                    OP_LW, OP_SW: state_d = S_MEMADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADDR:  state_d = is_store ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (memReady) state_d = S_MEMWB;
                        else if (timeout) state_d = S_FETCH;
            S_MEMWRITE: if (memReady || timeout) state_d = S_FETCH;
            S_EXEC:     state_d = S_RWB;
            S_ADDIEX:   state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // NOTE: control registers are few and cheap, so all of them take the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
            is_store <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            if (state_q == S_DECODE)
                is_store <= (opcode == OP_SW);
            // Any cycle that is not a continuing stall re-arms the count for the next wait.
            if (!stall)
                wait_cnt <= '0;
            else if (wait_cnt != '1)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_REG;
        aluCtl      = ALU_ADD;
        pcSource    = PC_ALU;
        illegalOp   = 1'b0;
        memTimeout  = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    memRead    = 1'b1;
                    aluSrcB    = SRCB_FOUR;
                    irWrite    = memReady;
                    pcWrite    = memReady;
                    memTimeout = timeout;
                end
                S_DECODE: begin
                    aluSrcB   = SRCB_IMM_SH2;
                    illegalOp = !((opcode == OP_RTYPE && fn_valid) || opcode == OP_LW ||
                                  opcode == OP_SW || opcode == OP_BEQ ||
                                  opcode == OP_J || opcode == OP_ADDI);
                end
                S_MEMADDR, S_ADDIEX: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_IMM;
                end
                S_MEMREAD: begin
                    memRead    = 1'b1;
                    iorD       = 1'b1;
                    memTimeout = timeout;
                end
                S_MEMWB: begin
                    regWrite = 1'b1;
                    memToReg = 1'b1;
                end
                S_MEMWRITE: begin
                    memWrite   = 1'b1;
                    iorD       = 1'b1;
                    memTimeout = timeout;
                end
                S_EXEC: begin
                    aluSrcA = 1'b1;
                    aluCtl  = fn_alu;
                end
                S_RWB: begin
                    regWrite = 1'b1;
                    regDst   = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA     = 1'b1;
                    aluCtl      = ALU_SUB;
                    pcWriteCond = 1'b1;
                    pcSource    = PC_ALUOUT;
                end
                S_JUMP: begin
                    pcWrite  = 1'b1;
                    pcSource = PC_JUMP;
                end
                S_ADDIWB:  regWrite = 1'b1;
                default: ;
            endcase
        end
        pcEn = pcWrite | (pcWriteCond & zero);
    end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle MIPS main controller: a Moore FSM that sequences the shared ALU, register file, memory port and PC across FETCH/DECODE/EXECUTE/MEM/WB.
- Drives the 3-bit ALU operation code directly: AND=000, OR=001, ADD=010, SUB=110, SLT=111.
- Stretches memory states on a memReady handshake and aborts stuck accesses via a watchdog.

Parameters:
- WAIT_MAX, 15, max consecutive memReady-low cycles in a wait state before abort; 0 disables the watchdog.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- memReady  in  1  memory completes access this cycle
- pcWrite, pcWriteCond, pcEn  out  1  each; pcEn = pcWrite | (pcWriteCond & zero)
- iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite, aluSrcA  out  1  each
- aluSrcB  out  2  00=B, 01=const 4, 10=sext imm, 11=sext imm<<2
- aluCtl  out  3  ALU operation code
- pcSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
- illegalOp  out  1  one-cycle pulse on undecodable instruction
- memTimeout  out  1  one-cycle pulse on watchdog abort
- state  out  4  current state, debug

Behaviour:
- States: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. The state register resets asynchronously to FETCH.
- While rst_n=0, all strobes, selects and pulses are forced to 0, and aluCtl is forced to 010.
- Outputs decode from state only, except that the irWrite/pcWrite gating in FETCH depends on memReady. Unlisted outputs are 0 and aluCtl defaults to 010.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluCtl=010, pcSource=00. irWrite=1 and pcWrite=1 only when memReady=1. Go to DECODE on memReady, otherwise stay.
- DECODE: aluSrcA=0, aluSrcB=11, aluCtl=010. Next state by opcode:
  - 0x00 -> EXEC, if funct is in {0x20,0x22,0x24,0x25,0x2A}
  - 0x23 or 0x2B -> MEMADDR
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> ADDIEX
  - anything else, including an R-type with an unknown funct: illegalOp=1 this cycle -> FETCH.
- MEMADDR: aluSrcA=1, aluSrcB=10, aluCtl=010. Go to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: memRead=1, iorD=1. Go to MEMWB on memReady.
- MEMWB: regWrite=1, memToReg=1, regDst=0 -> FETCH.
- MEMWRITE: memWrite=1, iorD=1. Go to FETCH on memReady.
- EXEC: aluSrcA=1, aluSrcB=00, aluCtl from funct: 0x20->010, 0x22->110, 0x24->000, 0x25->001, 0x2A->111 -> RWB.
- RWB: regWrite=1, regDst=1 -> FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluCtl=110, pcWriteCond=1, pcSource=01 -> FETCH.
- JUMP: pcWrite=1, pcSource=10 -> FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluCtl=010 -> ADDIWB.
- ADDIWB: regWrite=1, regDst=0 -> FETCH.
- Latency with memReady held at 1: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4 cycles. Each wait cycle adds 1.
- Watchdog:
  - The counter clears on entry to any wait state (FETCH, MEMREAD, MEMWRITE) and increments on each wait cycle with memReady=0.
  - If the counter equals WAIT_MAX-1 while memReady=0: memTimeout=1 that cycle, irWrite and pcWrite stay 0, and the next state is FETCH, abandoning the access.
  - memReady arriving on that same cycle wins: no timeout.
  - The counter saturates and never wraps.
- Reset asserted mid-instruction returns to FETCH immediately and clears the counter. No partial writeback completes after rst_n rises.
- opcode/funct are sampled only in DECODE and EXEC. Changes in other states are ignored.

Decomposition:
- Package mips_ctrl_pkg holds:
  - the state encoding constants
  - opcode and funct constants
  - ALU control codes 000/001/010/110/111
  - aluSrcB and pcSource encodings.
- Sub-module alu_ctl_decode: combinational funct -> {aluCtl[2:0], valid}. It is used by EXEC and by the DECODE legality check.

Test Plan:
- Reset, then R-type add (opcode 0x00, funct 0x20) with memReady=1 -> states 0,1,6,7,0; aluCtl=010 in EXEC; regWrite=regDst=1 in RWB; irWrite/pcWrite pulse exactly once.
- lw (0x23) with memReady low 2 cycles in MEMREAD -> 7 cycles total; iorD=1 and memRead=1 held for 3 cycles; memToReg=1 in MEMWB.
- beq (0x04): zero=1 -> pcEn=1, pcSource=01 in BRANCH; repeat with zero=0 -> pcEn=0; aluCtl=110 in both.
- Illegal opcode 0x3F, then R-type funct 0x03 -> illegalOp one-cycle pulse in DECODE each time; return to FETCH; no regWrite or memWrite.
- WAIT_MAX=4, sw with memReady held at 0 -> memTimeout pulses on the 4th MEMWRITE cycle; next state FETCH; memWrite drops. Repeat with memReady=1 on the 4th cycle -> no timeout.
- Assert rst_n=0 mid-MEMWRITE -> all outputs 0 while in reset and state=0; after release, FETCH with memRead=1 on the first cycle.
